spin_button_conditioner: RTL and testbench

- Upstream conditioner for the slot machine's spin push-button.
- Synchronises the raw pad signal, debounces it with a press/release state machine, and emits one stretched spin request per accepted press.
- spin_req drives the slot-machine master's data_in. The width is stretched so the slow divided-clock slot logic cannot miss it.
- Runs on the undivided board clock.

---
 rtl/slot_pkg.sv | 23 ++
 rtl/pulse_stretcher.sv | 53 +++++
 rtl/spin_button_conditioner.sv | 169 ++++++++++++++++
 tb/tb_spin_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slot_pkg
//  Purpose  : Shared types and constants for the slot-machine spin-button
//             front end.
//             btn_state_t - debounce FSM states (IDLE, PRESS_CHK, PRESSED,
//                           REL_CHK), explicitly 2 bits wide.
//             c_PRESS_W   - width of the accepted-press counter.
//  Revision : 1.0 - initial release
// ============================================================================
package slot_pkg;

    localparam int c_PRESS_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_stretcher
//  Purpose  : Turns a single-cycle trigger into a registered pulse exactly
//             PULSE_CYCLES clocks wide. A trigger while a pulse is running
//             reloads the counter (extends, never queues).
//  Ports    : clk   - clock
//             reset - synchronous, active-high reset
//             trig  - single-cycle load request
//             out   - stretched pulse, registered
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out
);

    localparam int              c_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [c_W-1:0]  c_LOAD = c_W'(PULSE_CYCLES);

    logic [c_W-1:0] r_cnt;
    logic [c_W-1:0] w_cnt_next;
    logic           r_out;

    always_comb begin
        w_cnt_next = r_cnt;
        if (trig) begin
            w_cnt_next = c_LOAD;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    // Output flop mirrors the next counter value so out is high in the same
    // cycle the counter holds a non-zero value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_out <= (w_cnt_next != '0);
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/spin_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : spin_button_conditioner
//  Purpose  : Spin push-button front end: two-flop synchroniser, press/release
//             debounce FSM, accepted-press counter and a stretched spin
//             request for the slow slot-machine logic.
//  Ports    : clk         - undivided board clock
//             reset       - synchronous, active-high reset
//             btn_raw     - asynchronous bouncy button level (1 = pressed)
//             spin_req    - stretched spin request (slot machine data_in)
//             btn_level   - debounced button level
//             press_count - accepted-press counter, wraps 255 -> 0
//  Options  : SPIN_AUTOREPEAT_EN - when defined, a held button re-fires a
//             spin request every REPEAT_CYCLES clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module spin_button_conditioner
    import slot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int PULSE_CYCLES    = 4,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_raw,
    output logic                 spin_req,
    output logic                 btn_level,
    output logic [c_PRESS_W-1:0] press_count
);

    // ------------------------------------------------------------------
    // Parameter legality, caught at elaboration
    // ------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("PULSE_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES <= PULSE_CYCLES) begin : g_bad_repeat
        $error("REPEAT_CYCLES must exceed PULSE_CYCLES");
    end

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 r_s1;
    logic                 r_s2;
    btn_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_btn_level;
    logic [c_PRESS_W-1:0] r_press_count;
    logic                 w_accept;
    logic                 w_repeat;
    logic                 w_trig;

    // ------------------------------------------------------------------
    // Synchroniser: everything downstream looks only at r_s2
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Acceptance is decoded combinationally so the stretcher loads on the
    // same edge that the FSM moves into PRESSED.
    assign w_accept = (r_state == PRESS_CHK) && r_s2 && (r_cnt == c_CNT_LAST);

`ifdef SPIN_AUTOREPEAT_EN
    localparam int                c_REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep;

    // Only steady PRESSED cycles advance the repeat timer; REL_CHK holds it
    // so a short release glitch resumes the same repeat phase.
    assign w_repeat = (r_state == PRESSED) && r_s2 && (r_rep == c_REP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep <= '0;
        end else if (w_accept || (r_state == IDLE)) begin
            r_rep <= '0;
        end else if ((r_state == PRESSED) && r_s2) begin
            r_rep <= w_repeat ? '0 : r_rep + 1'b1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign w_trig = w_accept | w_repeat;

    // ------------------------------------------------------------------
    // Debounce FSM with registered level and press counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_btn_level   <= 1'b0;
            r_press_count <= '0;
        end else begin
            if (w_trig) begin
                r_press_count <= r_press_count + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_s2) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!r_s2) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state     <= PRESSED;
                        r_btn_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!r_s2) begin
                        r_state <= REL_CHK;
                        r_cnt   <= '0;
                    end
                end
                REL_CHK: begin
                    if (r_s2) begin
                        r_state <= PRESSED;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state     <= IDLE;
                        r_btn_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    pulse_stretcher #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_stretch (
        .clk   (clk),
        .reset (reset),
        .trig  (w_trig),
        .out   (spin_req)
    );

    assign btn_level   = r_btn_level;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_spin_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spin_button_conditioner
//  Purpose  : Self-checking bench for spin_button_conditioner. A run-length
//             model of the button predicts spin_req, btn_level and
//             press_count every cycle; directed scenarios add hand-computed
//             literal expectations.
//  Options  : SPIN_AUTOREPEAT_EN - enables the auto-repeat scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spin_button_conditioner;

    localparam int c_D = 4;
    localparam int c_P = 3;
    localparam int c_R = 10;
`ifdef SPIN_AUTOREPEAT_EN
    localparam bit c_AUTO      = 1'b1;
    localparam int c_CLEAN_CNT = 2;
`else
    localparam bit c_AUTO      = 1'b0;
    localparam int c_CLEAN_CNT = 1;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_raw = 1'b0;
    logic       spin_req;
    logic       btn_level;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    spin_button_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .CNT_W           (4),
        .PULSE_CYCLES    (c_P),
        .REPEAT_CYCLES   (c_R)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .spin_req    (spin_req),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Model: the raw level reaches the logic two clocks late; a level change
    // is accepted once D+1 consecutive delayed samples disagree with the
    // current debounced level. Each accepted press (or repeat) counts and
    // starts a P-cycle request.
    // ------------------------------------------------------------------
    bit       m_s1, m_s2, m_level, m_fire;
    int       m_run, m_rem, m_rep;
    bit [7:0] m_count;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0;
            m_run = 0; m_rem = 0; m_rep = 0; m_count = 0;
        end else begin
            m_fire = 0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == c_D + 1) begin
                    m_level = m_s2;
                    m_run   = 0;
                    m_rep   = 0;
                    if (m_level) m_fire = 1;
                end
            end else begin
                // a held button (not recovering from a release glitch)
                if (m_level && m_run == 0) begin
                    m_rep++;
                    if (m_rep == c_R) begin
                        m_rep = 0;
                        if (c_AUTO) m_fire = 1;
                    end
                end
                m_run = 0;
            end
            if (m_fire) begin
                m_count++;
                m_rem = c_P;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    // ------------------------------------------------------------------
    // Every-cycle comparison and pulse bookkeeping
    // ------------------------------------------------------------------
    bit   chk_en  = 1'b0;
    logic prev_req = 1'b0;
    int   ncyc    = 0;
    int   pulses  = 0;
    int   rises[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_spin_req",    spin_req,    (m_rem != 0));
            check("model_btn_level",   btn_level,   m_level);
            check("model_press_count", press_count, m_count);
        end
        ncyc++;
        if (spin_req === 1'b1 && prev_req === 1'b0) begin
            pulses++;
            rises.push_back(ncyc);
        end
        prev_req = spin_req;
    end

    int base;
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // Reset state
        reset = 1'b1; btn_raw = 1'b0;
        repeat (3) tick();
        check("reset_spin_req",    spin_req,    0);
        check("reset_btn_level",   btn_level,   0);
        check("reset_press_count", press_count, 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Clean press: edge 0 is the first posedge seeing btn_raw=1
        base = pulses;
        btn_raw = 1'b1;
        repeat (6) tick();
        check("clean_req_edge5",   spin_req,  0);
        check("clean_level_edge5", btn_level, 0);
        tick();
        check("clean_req_edge6",   spin_req,  1);
        check("clean_level_edge6", btn_level, 1);
        tick();
        check("clean_req_edge7",   spin_req,  1);
        tick();
        check("clean_req_edge8",   spin_req,  1);
        tick();
        check("clean_req_edge9",   spin_req,  0);
        repeat (10) tick();
        check("clean_press_count", press_count, c_CLEAN_CNT);
        check("clean_pulses",      pulses - base, c_CLEAN_CNT);
        btn_raw = 1'b0;
        repeat (12) tick();
        check("clean_release_level", btn_level, 0);

        // Bounce rejection
        base = pulses;
        for (int i = 0; i < 7; i++) begin
            btn_raw = pat[i];
            tick();
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        check("bounce_pulses",      pulses - base, 0);
        check("bounce_press_count", press_count, c_CLEAN_CNT);
        check("bounce_level",       btn_level, 0);

        // Release debounce with a short release glitch
        btn_raw = 1'b1;
        repeat (12) tick();
        check("rel_pressed_level", btn_level, 1);
        base = pulses;
        btn_raw = 1'b0;
        repeat (3) tick();
        btn_raw = 1'b1;
        repeat (6) tick();
        check("rel_glitch_level", btn_level, 1);
`ifndef SPIN_AUTOREPEAT_EN
        check("rel_glitch_pulses", pulses - base, 0);
`endif
        btn_raw = 1'b0;
        repeat (6) tick();
        check("rel_level_edge5", btn_level, 1);
        tick();
        check("rel_level_edge6", btn_level, 0);
        repeat (4) tick();

        // Wrap: 256 press/release cycles from a fresh reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        base = pulses;
        for (int n = 0; n < 256; n++) begin
            btn_raw = 1'b1;
            repeat (8) tick();
            btn_raw = 1'b0;
            repeat (8) tick();
        end
        check("wrap_pulses",      pulses - base, 256);
        check("wrap_press_count", press_count, 0);

        // Reset in the middle of a stretch
        btn_raw = 1'b1;
        repeat (7) tick();
        check("rst_mid_req_high", spin_req, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_req",   spin_req,    0);
        check("rst_mid_level", btn_level,   0);
        check("rst_mid_count", press_count, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("rst_after_req_edge5", spin_req, 0);
        tick();
        check("rst_after_req_edge6", spin_req, 1);
        check("rst_after_count",     press_count, 1);
        btn_raw = 1'b0;
        repeat (12) tick();

`ifdef SPIN_AUTOREPEAT_EN
        // Auto-repeat: hold 35 cycles past acceptance
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rises.delete();
        btn_raw = 1'b1;
        repeat (42) tick();
        check("auto_pulses", rises.size(), 4);
        if (rises.size() == 4) begin
            for (int k = 1; k < 4; k++)
                check("auto_spacing", rises[k] - rises[k-1], 10);
        end
        check("auto_press_count", press_count, 4);
        btn_raw = 1'b0;
        repeat (12) tick();
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
